bus_xfer_decoder: RTL and testbench

BUS_XFER_DECODER -- requirements
Module: bus_xfer_decoder

---
 rtl/bus_xfer_decoder.sv | 152 +++++++++++++++
 tb/tb_bus_xfer_decoder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_decoder.sv
// -----------------------------------------------------------------------------
// bus_xfer_decoder
//
// Purpose:
//   This block sequences one register-to-register bus transfer.
//   In IDLE it accepts a request and captures the source and destination
//   codes. In DRIVE it enables the source driver. In LATCH it keeps the
//   source driver on and pulses the destination latch enable. It then
//   returns to IDLE and acknowledges the transfer.
//   When either code is out of range (27..31), the request is rejected.
//   The block pulses err and does not start a transfer.
//
// Bus bit order for out_en / in_en (bit index = code - 1):
//   0-15 R0..R15, 16 LO, 17 HI, 18 Zhigh, 19 Zlow, 20 PC, 21 IR,
//   22 MAR, 23 MDR, 24 InPort, 25 C
//
// Ports:
//   clk         system clock, rising edge
//   clr         synchronous active-high reset
//   req         transfer request, sampled only in IDLE
//   src_code    5-bit source code (0 = none, 1..26 = index + 1)
//   dst_code    5-bit destination code (0 = none, 1..26 = index + 1)
//   out_en      26-bit one-hot source drive enables (registered)
//   in_en       26-bit one-hot destination latch enables (registered)
//   busy        high while the FSM is in DRIVE or LATCH
//   ack         one-cycle pulse in the cycle after LATCH
//   err         one-cycle pulse after a rejected request
//   xfer_count  completed-transfer counter, CNT_W bits, wraps
//
// Configuration:
//   BUS_XFER_COUNT_EN  when defined, the transfer counter is built.
//                      When undefined, xfer_count is tied to zero.
// -----------------------------------------------------------------------------
module bus_xfer_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req,
    input  logic [4:0]       src_code,
    input  logic [4:0]       dst_code,
    output logic [25:0]      out_en,
    output logic [25:0]      in_en,
    output logic             busy,
    output logic             ack,
    output logic             err,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t      state_reg;
    logic [4:0]  src_reg;
    logic [4:0]  dst_reg;

    // src_in_dec feeds out_en on the capture edge. The DRIVE->LATCH edge
    // reloads out_en from the captured src_reg. Input changes after
    // capture therefore never reach the enables.
    logic [25:0] src_in_dec;
    logic [25:0] src_reg_dec;
    logic [25:0] dst_reg_dec;
    logic        codes_valid;

    // Code 0 and codes 27..31 match no bit, so each decode is one-hot or zero.
    generate
        for (genvar gi = 0; gi < 26; gi++) begin : g_dec
            assign src_in_dec[gi]  = (src_code == 5'(gi + 1));
            assign src_reg_dec[gi] = (src_reg  == 5'(gi + 1));
            assign dst_reg_dec[gi] = (dst_reg  == 5'(gi + 1));
        end
    endgenerate

    assign codes_valid = (src_code <= 5'd26) && (dst_code <= 5'd26);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            out_en    <= '0;
            in_en     <= '0;
            busy      <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    out_en <= '0;
                    in_en  <= '0;
                    busy   <= 1'b0;
                    if (req) begin
                        if (codes_valid) begin
                            src_reg   <= src_code;
                            dst_reg   <= dst_code;
                            out_en    <= src_in_dec;
                            busy      <= 1'b1;
                            state_reg <= DRIVE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    // The source stays driven while the destination latches.
                    out_en    <= src_reg_dec;
                    in_en     <= dst_reg_dec;
                    busy      <= 1'b1;
                    state_reg <= LATCH;
                end
                LATCH: begin
                    out_en    <= '0;
                    in_en     <= '0;
                    busy      <= 1'b0;
                    ack       <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    out_en    <= '0;
                    in_en     <= '0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef BUS_XFER_COUNT_EN
    logic [CNT_W-1:0] count_reg;

    // The counter advances on the same edge that raises ack. The new value
    // is therefore visible in the ack cycle. A clr in LATCH wins, so an
    // aborted transfer is never counted.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (state_reg == LATCH) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign xfer_count = count_reg;
`else
    assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_bus_xfer_decoder.sv
// -----------------------------------------------------------------------------
// tb_bus_xfer_decoder
//
// Directed testbench for bus_xfer_decoder, built with CNT_W = 4 so that a
// counter wrap takes only 16 transfers. Inputs are driven #1 after a rising
// edge. Outputs are sampled at that same point, so each sample shows the
// result of the edge just passed. The expected xfer_count follows a local
// transfer tally when BUS_XFER_COUNT_EN is defined, and is 0 otherwise.
// -----------------------------------------------------------------------------
module tb_bus_xfer_decoder;

    localparam int CNT_W = 4;

    logic             clk;
    logic             clr;
    logic             req;
    logic [4:0]       src_code;
    logic [4:0]       dst_code;
    logic [25:0]      out_en;
    logic [25:0]      in_en;
    logic             busy;
    logic             ack;
    logic             err;
    logic [CNT_W-1:0] xfer_count;

    int         checks;
    int         errors;
    logic [3:0] model_cnt;
    int         cycle;

    bus_xfer_decoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req),
        .src_code   (src_code),
        .dst_code   (dst_code),
        .out_en     (out_en),
        .in_en      (in_en),
        .busy       (busy),
        .ack        (ack),
        .err        (err),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_cnt();
`ifdef BUS_XFER_COUNT_EN
        return model_cnt;
`else
        return 4'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic test_reset();
        clr = 1'b1; req = 1'b1; src_code = 5'd3; dst_code = 5'd22;
        tick();
        tick();
        model_cnt = 4'd0;
        checks++;
        if (out_en !== 26'd0 || in_en !== 26'd0) begin
            errors++;
            $display("FAIL reset_enables: out_en=%h in_en=%h expected 0 0", out_en, in_en);
        end
        checks++;
        if ({busy, ack, err} !== 3'b000 || xfer_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags: busy/ack/err=%b count=%0d expected 000 0",
                     {busy, ack, err}, xfer_count);
        end
        clr = 1'b0; req = 1'b0;
        $display("reset: out_en=%h in_en=%h busy=%b count=%0d", out_en, in_en, busy, xfer_count);
    endtask

    task automatic test_basic();
        req = 1'b1; src_code = 5'd3; dst_code = 5'd22;
        tick();
        req = 1'b0;
        checks++;
        if (out_en !== 26'h0000004 || in_en !== 26'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_drive: out_en=%h in_en=%h busy=%b expected 0000004 0000000 1",
                     out_en, in_en, busy);
        end
        tick();
        checks++;
        if (out_en !== 26'h0000004 || in_en !== 26'h0200000 || ack !== 1'b0) begin
            errors++;
            $display("FAIL basic_latch: out_en=%h in_en=%h ack=%b expected 0000004 0200000 0",
                     out_en, in_en, ack);
        end
        tick();
        model_cnt++;
        checks++;
        if (ack !== 1'b1 || busy !== 1'b0 || out_en !== 26'd0 || in_en !== 26'd0
            || xfer_count !== exp_cnt()) begin
            errors++;
            $display("FAIL basic_ack: ack=%b busy=%b out_en=%h in_en=%h count=%0d expected 1 0 0 0 %0d",
                     ack, busy, out_en, in_en, xfer_count, exp_cnt());
        end
        tick();
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack_pulse: ack=%b expected 0", ack);
        end
        $display("basic: src=3 dst=22 count=%0d", xfer_count);
    endtask

    task automatic test_error();
        req = 1'b1; src_code = 5'd28; dst_code = 5'd1;
        tick();
        req = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || out_en !== 26'd0 || in_en !== 26'd0) begin
            errors++;
            $display("FAIL err_pulse: err=%b busy=%b out_en=%h in_en=%h expected 1 0 0 0",
                     err, busy, out_en, in_en);
        end
        tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || ack !== 1'b0 || xfer_count !== exp_cnt()) begin
            errors++;
            $display("FAIL err_after: err=%b busy=%b ack=%b count=%0d expected 0 0 0 %0d",
                     err, busy, ack, xfer_count, exp_cnt());
        end
        // An out-of-range destination code must be rejected too.
        req = 1'b1; src_code = 5'd1; dst_code = 5'd31;
        tick();
        req = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_dst: err=%b busy=%b expected 1 0", err, busy);
        end
        tick();
        $display("error: src=28 and dst=31 rejected, count=%0d", xfer_count);
    endtask

    task automatic test_ignore_busy();
        int acks;
        req = 1'b1; src_code = 5'd5; dst_code = 5'd2;
        tick();
        // Keep req high and change the codes while the transfer is busy.
        src_code = 5'd10; dst_code = 5'd9;
        checks++;
        if (out_en !== 26'h0000010 || in_en !== 26'd0) begin
            errors++;
            $display("FAIL busy_drive: out_en=%h in_en=%h expected 0000010 0000000", out_en, in_en);
        end
        tick();
        req = 1'b0;
        checks++;
        if (out_en !== 26'h0000010 || in_en !== 26'h0000002) begin
            errors++;
            $display("FAIL busy_latch: out_en=%h in_en=%h expected 0000010 0000002", out_en, in_en);
        end
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack === 1'b1) acks++;
        end
        model_cnt++;
        checks++;
        if (acks != 1 || busy !== 1'b0 || xfer_count !== exp_cnt()) begin
            errors++;
            $display("FAIL busy_single_ack: acks=%0d busy=%b count=%0d expected 1 0 %0d",
                     acks, busy, xfer_count, exp_cnt());
        end
        $display("ignore_busy: acks=%0d count=%0d", acks, xfer_count);
    endtask

    task automatic test_clr_abort();
        int acks;
        req = 1'b1; src_code = 5'd1; dst_code = 5'd26;
        tick();
        req = 1'b0;
        tick();
        checks++;
        if (out_en !== 26'h0000001 || in_en !== 26'h2000000) begin
            errors++;
            $display("FAIL abort_latch: out_en=%h in_en=%h expected 0000001 2000000", out_en, in_en);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_cnt = 4'd0;
        checks++;
        if (out_en !== 26'd0 || in_en !== 26'd0 || {busy, ack, err} !== 3'b000
            || xfer_count !== 4'd0) begin
            errors++;
            $display("FAIL abort_clear: out_en=%h in_en=%h busy/ack/err=%b count=%0d expected 0 0 000 0",
                     out_en, in_en, {busy, ack, err}, xfer_count);
        end
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0 || xfer_count !== 4'd0) begin
            errors++;
            $display("FAIL abort_no_ack: acks=%0d count=%0d expected 0 0", acks, xfer_count);
        end
        $display("clr_abort: acks=%0d count=%0d", acks, xfer_count);
    endtask

    task automatic test_zero_codes();
        req = 1'b1; src_code = 5'd0; dst_code = 5'd0;
        tick();
        req = 1'b0;
        checks++;
        if (out_en !== 26'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_drive: out_en=%h busy=%b expected 0 1", out_en, busy);
        end
        tick();
        checks++;
        if (in_en !== 26'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_latch: in_en=%h busy=%b expected 0 1", in_en, busy);
        end
        tick();
        model_cnt++;
        checks++;
        if (ack !== 1'b1 || xfer_count !== exp_cnt()) begin
            errors++;
            $display("FAIL zero_ack: ack=%b count=%0d expected 1 %0d", ack, xfer_count, exp_cnt());
        end
        tick();
        $display("zero_codes: count=%0d", xfer_count);
    endtask

    task automatic test_back_to_back();
        int last_ack;
        int bad_gap;
        int bad_hot;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_cnt = 4'd0;
        req = 1'b1; src_code = 5'd17; dst_code = 5'd21;
        bad_gap = 0;
        bad_hot = 0;
        last_ack = -1;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (out_en !== 26'h0010000 || !$onehot0(in_en)) bad_hot++;
            tick();
            if (out_en !== 26'h0010000 || in_en !== 26'h0100000) bad_hot++;
            if (t == 15) req = 1'b0;
            tick();
            model_cnt++;
            if (last_ack >= 0 && cycle - last_ack != 3) bad_gap++;
            last_ack = cycle;
            checks++;
            if (ack !== 1'b1 || xfer_count !== exp_cnt()) begin
                errors++;
                $display("FAIL b2b_ack_%0d: ack=%b count=%0d expected 1 %0d",
                         t, ack, xfer_count, exp_cnt());
            end
            $display("b2b transfer %0d: ack=%b count=%0d", t, ack, xfer_count);
        end
        checks++;
        if (bad_gap != 0 || bad_hot != 0) begin
            errors++;
            $display("FAIL b2b_timing: bad_gaps=%0d bad_enables=%0d expected 0 0", bad_gap, bad_hot);
        end
        checks++;
        if (xfer_count !== 4'd0) begin
            errors++;
            $display("FAIL b2b_wrap: count=%0d expected 0", xfer_count);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b ack=%b expected 0 0", busy, ack);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cycle     = 0;
        model_cnt = 4'd0;
        clr       = 1'b1;
        req       = 1'b0;
        src_code  = 5'd0;
        dst_code  = 5'd0;
        test_reset();
        test_basic();
        test_error();
        test_ignore_busy();
        test_zero_codes();
        test_clr_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
